// File: rtl/wb_write_demux.sv
// rtl/wb_write_demux.sv - single-entry write-back stage driving a one-hot register file write port
// Holds one write, drains it when the register file is free, and forwards the held value to read ports.
module wb_write_demux #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rf_hold,
    output logic [NREGS-1:0]  reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       commit_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    logic              drain;
    logic              accept;

    assign drain  = (state == FULL) && !rf_hold;
    // Zero-register requests are consumed while ready but never become an entry.
    assign accept = wr_valid && wr_ready && (wr_addr != ZERO_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (drain && !accept) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        wr_ready   = (state == EMPTY) || drain;
        reg_we     = '0;
        if (drain) reg_we[held_addr] = 1'b1;
        pend_valid = (state == FULL);
        pend_addr  = (state == FULL) ? held_addr : '0;
        fwd_a      = (state == FULL) && (rd_addr_a == held_addr);
        fwd_b      = (state == FULL) && (rd_addr_b == held_addr);
    end

    assign reg_wdata = held_data;
    assign fwd_data  = held_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_addr  <= '0;
            held_data  <= '0;
            commit_cnt <= '0;
        end else begin
            if (accept) begin
                held_addr <= wr_addr;
                held_data <= wr_data;
            end
            if (drain) commit_cnt <= commit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_write_demux.sv
// tb/tb_wb_write_demux.sv - vector-table bench for wb_write_demux
module tb_wb_write_demux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rf_hold;
    logic [31:0] reg_we;
    logic [63:0] reg_wdata;
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        fwd_a;
    logic        fwd_b;
    logic [63:0] fwd_data;
    logic [15:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_write_demux dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rf_hold(rf_hold), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .pend_valid(pend_valid), .pend_addr(pend_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data(fwd_data), .commit_cnt(commit_cnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [63:0] d;
        logic        h;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_rdy;
        logic [31:0] e_we;
        logic [63:0] e_wd;
        logic        e_pv;
        logic [4:0]  e_pa;
        logic        e_fa;
        logic        e_fb;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic v, logic [4:0] a, logic [63:0] d, logic h,
                                logic [4:0] ra, logic [4:0] rb, logic e_rdy,
                                logic [31:0] e_we, logic [63:0] e_wd, logic e_pv,
                                logic [4:0] e_pa, logic e_fa, logic e_fb, logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.h = h; r.ra = ra; r.rb = rb;
        r.e_rdy = e_rdy; r.e_we = e_we; r.e_wd = e_wd; r.e_pv = e_pv;
        r.e_pa = e_pa; r.e_fa = e_fa; r.e_fb = e_fb; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, " wr_ready"},   64'(wr_ready),   64'(t.e_rdy));
        check({tag, " reg_we"},     64'(reg_we),     64'(t.e_we));
        check({tag, " reg_wdata"},  reg_wdata,       t.e_wd);
        check({tag, " fwd_data"},   fwd_data,        t.e_wd);
        check({tag, " pend_valid"}, 64'(pend_valid), 64'(t.e_pv));
        check({tag, " pend_addr"},  64'(pend_addr),  64'(t.e_pa));
        check({tag, " fwd_a"},      64'(fwd_a),      64'(t.e_fa));
        check({tag, " fwd_b"},      64'(fwd_b),      64'(t.e_fb));
        check({tag, " commit_cnt"}, 64'(commit_cnt), 64'(t.e_cnt));
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic h, input logic [4:0] ra, input logic [4:0] rb);
        wr_valid = v; wr_addr = a; wr_data = d; rf_hold = h; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        // Each row: inputs for one cycle, outputs expected before the closing edge.
        //             v  a   d         h  ra rb  rdy we          wd        pv pa fa fb cnt
        tbl[0]  = mk(1, 5,  64'h1234, 0, 0, 0,  1, 32'h0,       64'h0,    0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1,  64'h11,   0, 0, 0,  1, 32'h20,      64'h1234, 1, 5, 0, 0, 0);
        tbl[2]  = mk(1, 2,  64'h22,   0, 0, 0,  1, 32'h2,       64'h11,   1, 1, 0, 0, 1);
        tbl[3]  = mk(1, 3,  64'h33,   0, 0, 0,  1, 32'h4,       64'h22,   1, 2, 0, 0, 2);
        tbl[4]  = mk(1, 7,  64'h77,   0, 0, 0,  1, 32'h8,       64'h33,   1, 3, 0, 0, 3);
        tbl[5]  = mk(1, 8,  64'h88,   1, 0, 0,  0, 32'h0,       64'h77,   1, 7, 0, 0, 4);
        tbl[6]  = mk(1, 8,  64'h88,   1, 0, 0,  0, 32'h0,       64'h77,   1, 7, 0, 0, 4);
        tbl[7]  = mk(1, 8,  64'h88,   1, 0, 0,  0, 32'h0,       64'h77,   1, 7, 0, 0, 4);
        tbl[8]  = mk(1, 8,  64'h88,   0, 0, 0,  1, 32'h80,      64'h77,   1, 7, 0, 0, 4);
        tbl[9]  = mk(0, 0,  64'h0,    0, 0, 0,  1, 32'h100,     64'h88,   1, 8, 0, 0, 5);
        tbl[10] = mk(1, 31, 64'hFFFF, 0, 0, 0,  1, 32'h0,       64'h88,   0, 0, 0, 0, 6);
        tbl[11] = mk(0, 0,  64'h0,    0, 0, 0,  1, 32'h0,       64'h88,   0, 0, 0, 0, 6);
        tbl[12] = mk(1, 4,  64'hABCD, 0, 0, 0,  1, 32'h0,       64'h88,   0, 0, 0, 0, 6);
        tbl[13] = mk(0, 0,  64'h0,    1, 4, 4,  0, 32'h0,       64'hABCD, 1, 4, 1, 1, 6);
        tbl[14] = mk(0, 0,  64'h0,    1, 4, 9,  0, 32'h0,       64'hABCD, 1, 4, 1, 0, 6);
        tbl[15] = mk(0, 0,  64'h0,    0, 0, 4,  1, 32'h10,      64'hABCD, 1, 4, 0, 1, 6);
        tbl[16] = mk(0, 0,  64'h0,    0, 0, 4,  1, 32'h0,       64'hABCD, 0, 0, 0, 0, 7);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].ra, tbl[i].rb);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i]);
            @(posedge clk); #1;
        end

        // Asynchronous reset while an entry for register 6 is stalled.
        drive(1, 6, 64'h66, 0, 6, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 6, 0);
        #1;
        check("held6 pend_valid", 64'(pend_valid), 64'd1);
        check("held6 pend_addr",  64'(pend_addr),  64'd6);
        check("held6 fwd_a",      64'(fwd_a),      64'd1);
        #1 reset_n = 1'b0;
        #1;
        check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #3 reset_n = 1'b1;
        drive(0, 0, 0, 0, 6, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d reg_we", i), 64'(reg_we), 64'h0);
            check($sformatf("post_rst%0d cnt", i), 64'(commit_cnt), 64'h0);
            check($sformatf("post_rst%0d pend_valid", i), 64'(pend_valid), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_demux.md
Name: wb_write_demux

Overview:
Write-back demultiplexer for the register file: the write-side counterpart of the read-port select muxes. Accepts one write request per cycle from the WB stage and holds it in a single-entry stage register. It drives a one-hot write-enable vector plus write data into the 32-entry register file, and exposes the pending write for same-cycle forwarding on two read ports. The zero register is never written.

Parameters:
ADDR_W, 5, register address width
DATA_W, 64, register data width
NREGS, 32, number of registers (= 2**ADDR_W)
ZERO_REG, 31, hard-wired zero register index; writes to it are discarded

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
wr_valid  input  1  WB write request valid
wr_addr  input  ADDR_W  destination register
wr_data  input  DATA_W  write data
wr_ready  output  1  request accepted this cycle when high with wr_valid
rf_hold  input  1  register file cannot take a write this cycle
reg_we  output  NREGS  one-hot write enable to register file
reg_wdata  output  DATA_W  write data to register file
pend_valid  output  1  held entry present
pend_addr  output  ADDR_W  address of held entry
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
fwd_a  output  1  port A must take fwd_data
fwd_b  output  1  port B must take fwd_data
fwd_data  output  DATA_W  held write data
commit_cnt  output  16  count of writes delivered to register file

Behaviour:
- Reset (async, reset_n low): state EMPTY, held addr/data = 0, commit_cnt = 0. Outputs: reg_we = 0, reg_wdata = 0, pend_valid = 0, pend_addr = 0, fwd_a/fwd_b = 0, fwd_data = 0, wr_ready = 1. Reset mid-operation drops any held entry without writing it.
- States: EMPTY (no held entry), FULL (held entry waiting to drain).
- drain = FULL && !rf_hold. In this cycle reg_we[held_addr] = 1, all other bits 0. reg_we = 0 whenever !drain.
- reg_wdata = held data at all times (0 after reset).
- wr_ready = EMPTY || drain, so it is combinational on rf_hold.
- accept = wr_valid && wr_ready && (wr_addr != ZERO_REG). A ZERO_REG request with wr_ready high is consumed and discarded: no state change, no reg_we, no count.
- Transitions at clock edge:
  - EMPTY + accept -> FULL and load the entry.
  - FULL + drain + accept -> FULL and load the new entry (back-to-back, no bubble).
  - FULL + drain + !accept -> EMPTY.
  - FULL + rf_hold -> FULL, entry unchanged, wr_ready = 0.
- Latency: a request accepted at edge N is presented on reg_we in the cycle after N (if rf_hold is low). The register file captures it at edge N+1.
- commit_cnt increments by 1 at each edge where drain was true. It wraps 0xFFFF -> 0x0000.
- Forwarding: fwd_a = FULL && (rd_addr_a == held_addr). fwd_b likewise for rd_addr_b. Both may be high together. No forwarding for rd_addr == ZERO_REG, since a held entry never has that address. Forwarding is independent of rf_hold.
- pend_valid = FULL and pend_addr = held_addr. pend_addr = 0 when EMPTY.
- reg_we is never multi-hot and is never asserted for ZERO_REG.

Test Plan:
- Reset, then wr_valid=1, addr=5, data=0x1234, rf_hold=0 -> wr_ready=1; the next cycle shows reg_we=0x00000020 and reg_wdata=0x1234; commit_cnt=1 after the following edge.
- Back-to-back writes to addr 1,2,3 on consecutive cycles with rf_hold=0 -> reg_we is 0x2, 0x4, 0x8 on consecutive cycles; wr_ready stays 1; commit_cnt=3.
- Hold addr 7 with rf_hold=1 for 3 cycles while wr_valid=1 addr=8 -> wr_ready=0 and reg_we=0 for 3 cycles with pend_addr=7. When rf_hold drops, reg_we=0x80 and addr 8 is accepted in the same cycle; reg_we=0x100 in the next cycle.
- Write to addr 31 with data 0xFFFF -> wr_ready=1, pend_valid stays 0, reg_we=0 throughout, commit_cnt unchanged.
- Held addr 4 with data 0xABCD and rd_addr_a=4, rd_addr_b=4 -> fwd_a=1, fwd_b=1, fwd_data=0xABCD. With rd_addr_b=9 instead -> fwd_b=0.
- Assert reset_n=0 mid-cycle with addr 6 held under rf_hold=1 -> pend_valid=0, reg_we=0, commit_cnt=0 immediately without waiting for a clock edge; after release no write to register 6 occurs.
